edge_bit_sampler: RTL and testbench
===================================

// Module: edge_bit_sampler
// PURPOSE
//  UART RX timing and sampling stage, directly upstream of the RX start/parity/stop checkers.
//  Counts oversampling edges within a bit (edge_cnt) and bits within a frame (bit_cnt).
//  Takes three mid-bit samples of RX_IN and majority-votes them into sampled_bit.
//  The checkers compare sampled_bit at edge_cnt==prescale-1.
//  Enables come from the RX FSM.
// PARAMETERS
//  edge_cnt_width  6  width of edge_cnt; must hold prescale-1
//  prescale_width  6  width of prescale; supported prescale values: 8, 16, 32
//  bit_cnt_width   4  width of bit_cnt; holds up to 11 frame bits
// PORTS
//  CLK           in   1                system clock
//  RST           in   1                reset, synchronous, active-low
//  RX_IN         in   1                serial line, already synchronised to CLK externally
//  cnt_en        in   1                FSM enable for the edge/bit counters
//  dat_samp_en   in   1                FSM enable for sampling
//  prescale      in   prescale_width   oversampling ratio; stable while cnt_en=1
//  edge_cnt      out  edge_cnt_width   edge index within the current bit, 0..prescale-1
//  bit_cnt       out  bit_cnt_width    bit index within the frame
//  sampled_bit   out  1                majority-voted value of the current bit
//  sample_valid  out  1                1-cycle pulse when sampled_bit is updated
// BEHAVIOUR
//  Reset (RST=0 at a CLK edge), all registered:
//   - edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0
//   - internal samples s0..s2 = 1
//   - reset wins over every other condition, including mid-frame.
//  Counters, priority highest first:
//   - cnt_en=0: edge_cnt<=0, bit_cnt<=0.
//   - edge_cnt>=prescale-1: edge_cnt<=0, bit_cnt<=bit_cnt+1.
//     The >= compare prevents runaway if prescale shrinks mid-bit.
//   - otherwise: edge_cnt<=edge_cnt+1, bit_cnt holds.
//   - bit_cnt wraps modulo 2^bit_cnt_width; the FSM drops cnt_en before the wrap.
//  Sampling, with mid=prescale>>1; compares use the current registered edge_cnt:
//   - dat_samp_en=0: s0..s2<=1, sampled_bit<=1, sample_valid<=0.
//   - dat_samp_en=1:
//     - s0<=RX_IN at edge_cnt==mid-2; s1<=RX_IN at mid-1; s2<=RX_IN at mid.
//     - at edge_cnt==mid+1: sampled_bit<=maj(s0,s1,s2), sample_valid<=1.
//     - all other cycles: sample_valid<=0, sampled_bit holds.
//   - new sampled_bit is visible while edge_cnt==mid+2, i.e. before the checker
//     compare at edge_cnt==prescale-1.
//   - sample_valid is high for exactly one cycle per bit.
//  Simultaneous events:
//   - cnt_en=0 with dat_samp_en=1: counters clear and edge_cnt re-enters 0.
//     Sampling follows the new edge_cnt, so no stale vote is produced.
//  Unsupported prescale values (not 8/16/32) give unspecified samples; counters must still wrap.
// TESTING
//  1 RST=0 for 2 cycles with random inputs -> edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0.
//  2 prescale=8, cnt_en=1 for 16 cycles
//    -> edge_cnt 0..7,0..7; bit_cnt 0->1 on the 1st wrap, 1->2 on the 2nd.
//  3 prescale=8, RX_IN=0 except 1 at edge_cnt==3
//    -> s=(0,1,0), sampled_bit=0; sample_valid high only while edge_cnt==6.
//  4 prescale=16, RX_IN=1 at edges 6,8 and 0 at edge 7 -> sampled_bit=1 with one pulse at edge_cnt==10.
//  5 cnt_en 1->0 at edge_cnt==5, bit_cnt==3 -> next cycle edge_cnt=0, bit_cnt=0, no sample_valid.
//  6 prescale changed 32->8 at edge_cnt==12 -> next cycle edge_cnt=0 and bit_cnt increments.

Source files
------------

// File: rtl/edge_bit_sampler.sv
// UART RX oversampling stage: edge/bit counters plus a three-sample majority
// vote of RX_IN around the middle of each bit.
module edge_bit_sampler #(
  parameter int edge_cnt_width = 6,
  parameter int prescale_width = 6,
  parameter int bit_cnt_width  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      cnt_en,
  input  logic                      dat_samp_en,
  input  logic [prescale_width-1:0] prescale,
  output logic [edge_cnt_width-1:0] edge_cnt,
  output logic [bit_cnt_width-1:0]  bit_cnt,
  output logic                      sampled_bit,
  output logic                      sample_valid
);

  // One spare bit so mid-2 / prescale-1 underflow never aliases a real edge.
  localparam int CW = ((edge_cnt_width > prescale_width) ? edge_cnt_width : prescale_width) + 1;

  logic [CW-1:0] edge_x, pre_x, mid_x;
  logic          last_edge, at_s0, at_s1, at_s2, at_vote, vote;
  logic [2:0]    s;

  always_comb begin
    edge_x    = CW'(edge_cnt);
    pre_x     = CW'(prescale);
    mid_x     = pre_x >> 1;
    last_edge = (edge_x >= pre_x - CW'(1));
    // With cnt_en low the counters are being cleared, so no sample point applies.
    at_s0     = cnt_en && (edge_x == mid_x - CW'(2));
    at_s1     = cnt_en && (edge_x == mid_x - CW'(1));
    at_s2     = cnt_en && (edge_x == mid_x);
    at_vote   = cnt_en && (edge_x == mid_x + CW'(1));
    vote      = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (last_edge) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s            <= '1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else if (!dat_samp_en) begin
      s            <= '1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      if (at_s0) s[0] <= RX_IN;
      if (at_s1) s[1] <= RX_IN;
      if (at_s2) s[2] <= RX_IN;
      sample_valid <= at_vote;
      if (at_vote) sampled_bit <= vote;
    end
  end

endmodule

// File: tb/tb_edge_bit_sampler.sv
// Scoreboard bench for edge_bit_sampler: stimulus queues expected per-cycle
// counter state and expected votes; monitors pop and compare on the falling edge.
module tb_edge_bit_sampler;

  logic       CLK = 1'b0;
  logic       RST, RX_IN, cnt_en, dat_samp_en;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit, sample_valid;

  edge_bit_sampler #(
    .edge_cnt_width(6),
    .prescale_width(6),
    .bit_cnt_width(4)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .cnt_en(cnt_en),
    .dat_samp_en(dat_samp_en), .prescale(prescale), .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt), .sampled_bit(sampled_bit), .sample_valid(sample_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cyc;
    int ec;
    int bc;
    int chk_sb;
    int sb;
    int valid;
  } exp_t;

  typedef struct {
    int sb;
    int ec;
  } vote_t;

  exp_t  cq[$];
  vote_t vq[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_now(input int ec, input int bc, input int chk_sb, input int sb, input int valid);
    exp_t e;
    e.cyc = cyc; e.ec = ec; e.bc = bc; e.chk_sb = chk_sb; e.sb = sb; e.valid = valid;
    cq.push_back(e);
  endtask

  task automatic expect_vote(input int sb, input int ec);
    vote_t v;
    v.sb = sb; v.ec = ec;
    vq.push_back(v);
  endtask

  // Per-cycle state monitor
  always @(negedge CLK) begin
    while (cq.size() > 0 && cq[0].cyc <= cyc) begin
      exp_t e;
      e = cq.pop_front();
      if (e.cyc < cyc) chk("stale_expectation", e.cyc, cyc);
      else begin
        chk("edge_cnt", int'(edge_cnt), e.ec);
        chk("bit_cnt", int'(bit_cnt), e.bc);
        chk("sample_valid", int'(sample_valid), e.valid);
        if (e.chk_sb != 0) chk("sampled_bit", int'(sampled_bit), e.sb);
      end
    end
  end

  // Vote monitor: every sample_valid pulse must match a queued vote
  always @(negedge CLK) begin
    if (sample_valid === 1'b1) begin
      if (vq.size() == 0) chk("unexpected_sample_valid", 1, 0);
      else begin
        vote_t v;
        v = vq.pop_front();
        chk("vote_value", int'(sampled_bit), v.sb);
        chk("vote_edge", int'(edge_cnt), v.ec);
      end
    end
  end

  initial begin
    // Reset with random inputs
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      RX_IN = 1'($urandom); cnt_en = 1'($urandom);
      dat_samp_en = 1'($urandom); prescale = 6'($urandom);
      step();
      expect_now(0, 0, 1, 1, 0);
    end

    // Counter sweep, prescale 8
    RST = 1'b1; cnt_en = 1'b1; dat_samp_en = 1'b0; prescale = 6'd8; RX_IN = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      expect_now(i % 8, i / 8, 1, 1, 0);
    end

    // Vote (0,1,0) -> 0, prescale 8
    cnt_en = 1'b0; dat_samp_en = 1'b0;
    step();
    expect_now(0, 0, 1, 1, 0);
    cnt_en = 1'b1; dat_samp_en = 1'b1;
    expect_vote(0, 6);
    for (int k = 0; k < 8; k++) begin
      RX_IN = (k == 3);
      step();
      expect_now((k + 1) % 8, (k == 7) ? 1 : 0, 1, (k + 1 >= 6 || k == 7) ? 0 : 1,
                 (k + 1 == 6) ? 1 : 0);
    end

    // Vote (1,0,1) -> 1, prescale 16
    cnt_en = 1'b0; dat_samp_en = 1'b0;
    step();
    expect_now(0, 0, 1, 1, 0);
    cnt_en = 1'b1; dat_samp_en = 1'b1; prescale = 6'd16;
    expect_vote(1, 10);
    for (int k = 0; k < 16; k++) begin
      RX_IN = (k == 6 || k == 8);
      step();
      expect_now((k + 1) % 16, (k == 15) ? 1 : 0, 1, 1, (k + 1 == 10) ? 1 : 0);
    end

    // cnt_en drop at edge 5 / bit 3 with sampling still enabled
    cnt_en = 1'b0; dat_samp_en = 1'b0; prescale = 6'd8;
    step();
    expect_now(0, 0, 1, 1, 0);
    cnt_en = 1'b1; dat_samp_en = 1'b1; RX_IN = 1'b0;
    for (int k = 0; k < 29; k++) begin
      step();
      if ((k + 1) % 8 == 6) expect_vote(0, 6);
      if (k == 28) expect_now(5, 3, 1, 0, 0);
    end
    cnt_en = 1'b0;
    step();
    expect_now(0, 0, 1, 0, 0);
    step();
    expect_now(0, 0, 1, 0, 0);

    // prescale shrinks 32 -> 8 at edge 12
    cnt_en = 1'b0; dat_samp_en = 1'b0; prescale = 6'd32;
    step();
    expect_now(0, 0, 1, 1, 0);
    cnt_en = 1'b1;
    for (int k = 0; k < 12; k++) step();
    expect_now(12, 0, 1, 1, 0);
    prescale = 6'd8;
    step();
    expect_now(0, 1, 1, 1, 0);
    step();
    expect_now(1, 1, 1, 1, 0);

    cnt_en = 1'b0;
    step();
    step();
    chk("vote_queue_drained", vq.size(), 0);
    chk("cycle_queue_drained", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
